hazard_unit_mc: RTL and testbench

Parametrised next-generation hazard unit for the 5-stage pipelined RISC-V core.
- Forwarding: E-stage operand forwarding from M and W.
- Loads: load-use stalls of configurable length, for multi-cycle data memory.
- Multi-cycle ops: stalls the front end while a multi-cycle E-stage unit (mul/div) is busy, using a start/done handshake.
- Control flow: flushes on taken branch/jump.
- Sits beside the datapath; drives stall/flush enables of the F/D, D/E and E/M pipeline registers.

---
 rtl/hazard_unit_mc.sv | 183 ++++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use stall, multi-cycle op stall and
// branch flush control for a 5-stage pipelined RISC-V core.
// Optional performance counters are built when the macro
// HAZARD_PERF_CNT_EN is defined (adds StallCycles / FlushEvents ports).
module hazard_unit_mc #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        PCSrcE,
  input  logic              McStartE,
  input  logic              McDone,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushEvents
`endif
);

  // Reject out-of-range configurations at elaboration.
  if (LOAD_LAT < 1 || LOAD_LAT > 8) begin : g_bad_load_lat
    $error("hazard_unit_mc: LOAD_LAT must be in 1..8");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_unit_mc: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] ld_cnt;   // remaining load-use stall cycles after the first

  logic ld_haz;
  logic br;
  logic mc;

  assign ld_haz = ResultSrcE[0] && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
  assign br     = (PCSrcE != 2'b00);
  assign mc     = McStartE && !McDone;

  // Forwarding select for one E-stage source operand; M has priority over W.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (rs != '0 && rs == RdM && RegWriteM)      fwd_sel = 2'b10;
    else if (rs != '0 && rs == RdW && RegWriteW) fwd_sel = 2'b01;
    else                                         fwd_sel = 2'b00;
  endfunction

  // Operand forwarding, forced to zero while in reset.
  always_comb begin
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
    if (rst) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  // Stall/flush enables as a function of FSM state and current hazards.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    McBusy = 1'b0;
    unique case (state)
      IDLE: begin
        if (br) begin
          // The dependent instruction is squashed, so branch wins.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (mc) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end else if (ld_haz) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      LD_STALL: begin
        // E holds a bubble here, so a branch indication is meaningless.
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      MC_BUSY: begin
        McBusy = 1'b1;
        if (!McDone) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      McBusy = 1'b0;
    end
  end

  // State and load-stall counter update.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state  <= IDLE;
      ld_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (br) begin
            state <= IDLE;
          end else if (mc) begin
            state <= MC_BUSY;
          end else if (ld_haz && LOAD_LAT > 1) begin
            ld_cnt <= 4'(LOAD_LAT - 1);
            state  <= LD_STALL;
          end
        end
        LD_STALL: begin
          ld_cnt <= ld_cnt - 4'd1;
          if (ld_cnt == 4'd1) state <= IDLE;
        end
        MC_BUSY: begin
          if (McDone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of front-end stall cycles and D-stage flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (StallF && StallCycles != '1) StallCycles <= StallCycles + 1'b1;
      if (FlushD && FlushEvents != '1) FlushEvents <= FlushEvents + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed testbench for hazard_unit_mc (LOAD_LAT=3). Define
// HAZARD_PERF_CNT_EN to also cover the performance counters.
module tb_hazard_unit_mc;

  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]        ResultSrcE, PCSrcE;
  logic              RegWriteM, RegWriteW, McStartE, McDone;
  logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
  logic [1:0]        ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  StallCycles, FlushEvents;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .McStartE(McStartE), .McDone(McDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .FlushEvents(FlushEvents)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control vector: {StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy}
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy};
  endfunction

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LD   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0001100;
  localparam logic [6:0] C_MC   = 7'b1110011;  // stalled inside MC_BUSY
  localparam logic [6:0] C_DONE = 7'b0000001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; PCSrcE = 2'b00;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    McStartE = 1'b0; McDone = 1'b0;
  endtask

  initial begin
    // Reset with hazard-provoking inputs: all outputs must stay 0.
    rst = 1'b1;
    clear_inputs();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    McStartE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #2;
    check("rst_ctl", 32'(ctl()), 32'(C_NONE));
    check("rst_fwdA", 32'(ForwardAE), 32'd0);
    tick(); tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("idle_ctl", 32'(ctl()), 32'(C_NONE));

    // 1. Forwarding
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    #1;
    check("fwdA_M", 32'(ForwardAE), 32'h2);
    Rs1E = 5'd0;
    #1;
    check("fwdA_x0", 32'(ForwardAE), 32'h0);
    Rs1E = 5'd5; RegWriteM = 1'b0;
    #1;
    check("fwdA_W", 32'(ForwardAE), 32'h1);
    Rs2E = 5'd5; RdW = 5'd6;
    #1;
    check("fwdB_none", 32'(ForwardBE), 32'h0);
    RdM = 5'd9; RegWriteM = 1'b1; Rs2E = 5'd9;
    #1;
    check("fwdB_M", 32'(ForwardBE), 32'h2);
    clear_inputs();
    tick();

    // 2. Load-use with LOAD_LAT=3: exactly three stall cycles.
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    check("ld_c0", 32'(ctl()), 32'(C_LD));
    tick();
    ResultSrcE = 2'b00; RdE = 5'd0; PCSrcE = 2'b01;  // bubble in E; branch ignored
    #1;
    check("ld_c1_br_ignored", 32'(ctl()), 32'(C_LD));
    tick();
    PCSrcE = 2'b00;
    #1;
    check("ld_c2", 32'(ctl()), 32'(C_LD));
    tick();
    #1;
    check("ld_done", 32'(ctl()), 32'(C_NONE));
    clear_inputs();
    tick();

    // 3. Load-use coinciding with a taken branch: flush only.
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 2'b01;
    #1;
    check("ldbr_c0", 32'(ctl()), 32'(C_BR));
    tick();
    clear_inputs();
    #1;
    check("ldbr_no_ldstall", 32'(ctl()), 32'(C_NONE));

`ifdef HAZARD_PERF_CNT_EN
    // 6. Counters after scenarios 2 and 3.
    check("perf_stall", StallCycles, 32'd3);
    check("perf_flush", FlushEvents, 32'd1);
`endif
    tick();

    // 4. Multi-cycle op: McDone low for 4 cycles, then high.
    McStartE = 1'b1; McDone = 1'b0;
    #1;
    check("mc_c0", 32'(ctl() >> 1), 32'(C_MC >> 1));
    for (int i = 1; i < 4; i++) begin
      tick();
      #1;
      check($sformatf("mc_c%0d", i), 32'(ctl()), 32'(C_MC));
    end
    tick();
    McDone = 1'b1;
    #1;
    check("mc_done", 32'(ctl()), 32'(C_DONE));
    tick();
    McStartE = 1'b0; McDone = 1'b0;
    #1;
    check("mc_idle", 32'(ctl()), 32'(C_NONE));
    tick();

    // Zero-latency op: no stall, stays IDLE.
    McStartE = 1'b1; McDone = 1'b1;
    #1;
    check("mc_zero_lat", 32'(ctl()), 32'(C_NONE));
    tick();
    McStartE = 1'b0; McDone = 1'b0;
    #1;
    check("mc_zero_after", 32'(ctl()), 32'(C_NONE));
    tick();

    // 5. Reset during MC_BUSY.
    McStartE = 1'b1;
    tick();
    #1;
    check("mcrst_busy", 32'(ctl()), 32'(C_MC));
    tick();
    rst = 1'b1;
    Rs1E = 5'd3; RdW = 5'd3; RegWriteW = 1'b1;
    #1;
    check("mcrst_ctl", 32'(ctl()), 32'(C_NONE));
    check("mcrst_fwdA", 32'(ForwardAE), 32'h0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("mcrst_after", 32'(ctl()), 32'(C_NONE));
    tick();
    #1;
    check("mcrst_after2", 32'(ctl()), 32'(C_NONE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
